// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per cycle.
// Signed/unsigned operands, divide-by-zero shortcut, and in-flight annul.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DZERO, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_signed;
  logic             r_s1;
  logic             r_s2;
  logic             r_dz;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_raw1;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_s1;
  logic             w_s2;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;

  assign w_accept = (r_state == S_IDLE) && start_i && !annul_i;
  assign w_s1     = signed_div_i & opdata1_i[WIDTH-1];
  assign w_s2     = signed_div_i & opdata2_i[WIDTH-1];
  assign w_mag1   = w_s1 ? -opdata1_i : opdata1_i;
  assign w_mag2   = w_s2 ? -opdata2_i : opdata2_i;

  // Remainder stays below the divisor, so a 33-bit trial never wraps.
  assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial  = w_shift - {1'b0, r_dsr};

  assign w_q = (r_signed && (r_s1 ^ r_s2)) ? -r_dvd : r_dvd;
  assign w_r = (r_signed && r_s1)          ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (opdata2_i == '0) ? S_DZERO : S_BUSY;
      S_BUSY: begin
        if (annul_i)                        w_next = S_IDLE;
        else if (r_cnt == CW'(WIDTH - 1))   w_next = S_DONE;
      end
      S_DZERO: w_next = annul_i ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_signed <= 1'b0;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_dz     <= 1'b0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_raw1   <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      busy_o  <= (w_next == S_BUSY) || (w_next == S_DZERO);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_signed <= signed_div_i;
            r_s1     <= w_s1;
            r_s2     <= w_s2;
            r_dvd    <= w_mag1;
            r_dsr    <= w_mag2;
            r_raw1   <= opdata1_i;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_dz     <= 1'b0;
          end
        end
        S_BUSY: begin
          if (!annul_i) begin
            r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DZERO: begin
          // Divide-by-zero reports the raw dividend and bypasses sign correction.
          r_dvd <= '1;
          r_rem <= r_raw1;
          r_dz  <= 1'b1;
        end
        S_DONE: begin
          if (!annul_i) begin
            ready_o  <= 1'b1;
            result_o <= r_dz ? {r_rem, r_dvd} : {w_r, w_q};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: stimulus pushes expected results into a queue,
// an independent monitor pops and compares whenever ready_o pulses.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [63:0] last_res = '0;

  typedef struct {
    logic [63:0] res;
    int          e0;
    int          lat;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  div_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every ready_o pulse must match the oldest outstanding request.
  initial begin
    forever begin
      @(negedge clk);
      if (ready_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: actual=ready with empty queue required=no ready (cycle %0d)", cyc);
        end else begin
          m = sb.pop_front();
          chk({m.nm, "_result"}, result_o, m.res);
          chk({m.nm, "_latency"}, 64'(cyc - m.e0), 64'(m.lat));
        end
      end
    end
  end

  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input int nbusy,
                        input string nm, input bit chg);
    exp_t e;
    int   bcnt;
    bit   got;
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    e.res = exp; e.e0 = cyc + 1; e.lat = lat; e.nm = nm;
    sb.push_back(e);
    bcnt = 0;
    got  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (chg) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sg;
      end
      if (ready_o) begin
        got = 1'b1;
        break;
      end
      if (busy_o) bcnt++;
    end
    start_i = 1'b0;
    chk({nm, "_ready_seen"}, 64'(got), 64'd1);
    chk({nm, "_busy_at_ready"}, 64'(busy_o), 64'd0);
    chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(nbusy));
    @(negedge clk);
    chk({nm, "_ready_pulse"}, 64'(ready_o), 64'd0);
    last_res = exp;
  endtask

  initial begin
    #2_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: actual=time limit reached required=completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b0; start_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_result", result_o, 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    rst = 1'b1;

    do_div(1'b0, 32'd100,       32'd7,       {32'h00000002, 32'h0000000E}, 33, 32, "u100_7", 1'b0);
    do_div(1'b1, 32'hFFFFFFF9,  32'd2,       {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 32, "s_m7_2", 1'b0);
    do_div(1'b0, 32'hFFFFFFF9,  32'd2,       {32'h00000001, 32'h7FFFFFFC}, 33, 32, "u_m7_2", 1'b0);
    do_div(1'b1, 32'h80000000,  32'hFFFFFFFF,{32'h00000000, 32'h80000000}, 33, 32, "s_ovf", 1'b0);
    do_div(1'b0, 32'hFFFFFFFF,  32'd1,       {32'h00000000, 32'hFFFFFFFF}, 33, 32, "u_max_1", 1'b0);
    do_div(1'b0, 32'd5,         32'd0,       {32'h00000005, 32'hFFFFFFFF}, 2,  1,  "u_dz", 1'b0);
    do_div(1'b1, 32'hFFFFFFFB,  32'd0,       {32'hFFFFFFFB, 32'hFFFFFFFF}, 2,  1,  "s_dz", 1'b0);
    do_div(1'b1, 32'd7,         32'hFFFFFFFE,{32'h00000001, 32'hFFFFFFFD}, 33, 32, "s_7_m2", 1'b0);
    do_div(1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,{32'hFFFFFFFE, 32'h0000000E}, 33, 32, "s_m100_m7", 1'b0);
    do_div(1'b0, 32'd1000,      32'd7,       {32'h00000006, 32'h0000008E}, 33, 32, "opchg", 1'b1);

    // Annul ten cycles into BUSY.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_busy", 64'(busy_o), 64'd0);
    chk("annul_ready", 64'(ready_o), 64'd0);
    chk("annul_result", result_o, last_res);
    repeat (40) @(negedge clk);
    do_div(1'b0, 32'd9, 32'd3, {32'h00000000, 32'h00000003}, 33, 32, "after_annul", 1'b0);

    // Annul while in DZERO.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul_dz_busy", 64'(busy_o), 64'd0);
    chk("annul_dz_result", result_o, last_res);
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-BUSY.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_result", result_o, 64'd0);
    chk("midrst_ready", 64'(ready_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    last_res = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (36) @(negedge clk);
    do_div(1'b0, 32'hFFFFFFFF, 32'd1, {32'h00000000, 32'hFFFFFFFF}, 33, 32, "after_rst", 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential 32-bit radix-2 divider, one quotient bit per cycle. Serves the ALU's divide request/ready handshake: DIV/DIVU issue, stall the pipeline while the unit is busy, and take a 64-bit {remainder, quotient} result in HI/LO layout. Handles signed and unsigned operands and divide-by-zero. Supports cancellation when the pipeline flushes.

## Interface
Parameters:
- WIDTH, 32, operand width; result_o is 2*WIDTH. Only 32 is verified.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  request; sampled only in IDLE.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
- opdata1_i  in  32  dividend; sampled with start_i.
- opdata2_i  in  32  divisor; sampled with start_i.
- annul_i  in  1  abort the operation in flight.
- result_o  out  64  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  one-cycle pulse; result_o is valid.
- busy_o  out  1  high in BUSY and DZERO.

## Operation
- States: IDLE, BUSY, DZERO, DONE.
- **IDLE**
  - start_i=1 and annul_i=0: latch signed_div, operand signs, and magnitudes. In signed mode, negative operands are two's-complemented; in unsigned mode operands are latched raw.
  - Clear the iteration counter and remainder accumulator.
  - Next state: DZERO if the divisor is 0, else BUSY.
  - start_i=1 with annul_i=1 is ignored.
- **BUSY**
  - Restoring shift-subtract, once per cycle. Shift {rem, dvd} left 1. If the 33-bit trial rem − divisor is non-negative, rem takes the trial value and the new quotient LSB is 1; otherwise the LSB is 0.
  - Counter runs 0..31. At count 31, go to DONE.
- **DZERO**
  - Quotient 0xFFFFFFFF, remainder = raw opdata1 (not the magnitude). Sign correction is not applied.
  - Next state: DONE.
- **DONE**
  - Register result_o. In signed mode, the quotient is negated if dividend sign ≠ divisor sign, and the remainder is negated if the dividend is negative.
  - ready_o=1 for this one cycle only. Next state: IDLE unconditionally.
- **annul_i** in BUSY, DZERO or DONE:
  - Next edge goes to IDLE. ready_o stays 0 and result_o is not updated.
  - annul_i has priority over completion.
- Operand changes after acceptance have no effect, because operands are latched.
- result_o holds its last value until the next DONE.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No flag is raised.
- start_i still high in the cycle after DONE (IDLE) starts a new division. The requester must drop start_i in the ready_o cycle if it wants no repeat.

## Timing
- Reset values: result_o=0, ready_o=0, busy_o=0, state=IDLE, counter=0.
- Latency, with start sampled at edge E0 and all outputs registered:
  - Normal divide: BUSY covers the 32 cycles after E0; ready_o is high in cycle 33 after E0.
  - Divide-by-zero: DZERO in cycle 1, ready_o high in cycle 2.
- Throughput: a new start is accepted in the cycle after ready_o, giving one result per 34 cycles.
- busy_o rises the cycle after acceptance. It falls when DONE is entered and is 0 during the ready_o cycle.
- Reset asserted mid-operation clears everything immediately, with no ready_o. The first start after deassertion is accepted normally.

## Test plan
- Unsigned 100 / 7, start held until ready -> ready_o exactly 33 cycles after the start edge; result_o = {0x00000002, 0x0000000E}; busy_o high for 32 cycles.
- Signed −7 (0xFFFFFFF9) / 2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Same operands unsigned -> {0x00000001, 0x7FFFFFFC}.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF / 1 -> {0x00000000, 0xFFFFFFFF}.
- Divide-by-zero, unsigned 5 / 0 -> ready_o 2 cycles after start; result_o = {0x00000005, 0xFFFFFFFF}.
- annul_i pulsed 10 cycles into BUSY:
  - Required: no ready_o, busy_o low next cycle, result_o unchanged.
  - Then start 9 / 3 -> {0, 3} with the normal 33-cycle latency.
- rst pulled low mid-BUSY, with opdata changed during BUSY in a separate run:
  - Reset run: all outputs 0 immediately, no ready_o.
  - Opdata-change run: the result uses the operands latched at start.
